// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit bus bridge.
//   lsu_state_t     - bridge FSM states (IDLE, REQ, DONE)
//   F3_*            - Funct3 access size/sign encodings
//   TIMEOUT_DEFAULT - default number of REQ cycles before an access is aborted
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_format.sv
// lsu_format: purely combinational access formatting.
//   Request side (live core inputs):
//     is_store, req_funct3, req_addr_lo, store_data -> legal, bus_wdata, bus_wstrb
//   Load side (registered access attributes and captured bus word):
//     ld_funct3, ld_addr_lo, rdata_word -> load_data (extracted and extended)
module lsu_format
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] store_data,
    output logic        legal,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata_word,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Unsigned variants exist only for loads; halfword/word need natural alignment.
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~req_addr_lo[0];
            F3_W:    legal = (req_addr_lo == 2'b00);
            F3_BU:   legal = ~is_store;
            F3_HU:   legal = ~is_store & ~req_addr_lo[0];
            default: legal = 1'b0;
        endcase
    end

    // Store data is replicated across all lanes so the slave can take it from
    // whichever lane the strobe selects.
    always_comb begin
        bus_wdata = store_data;
        bus_wstrb = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                bus_wdata = {4{store_data[7:0]}};
                bus_wstrb = 4'b0001 << req_addr_lo;
            end
            2'b01: begin
                bus_wdata = {2{store_data[15:0]}};
                bus_wstrb = 4'b0011 << {req_addr_lo[1], 1'b0};
            end
            default: begin
                bus_wdata = store_data;
                bus_wstrb = 4'b1111;
            end
        endcase
    end

    assign ld_byte = rdata_word[{ld_addr_lo, 3'b000} +: 8];
    assign ld_half = rdata_word[{ld_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata_word;
        case (ld_funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {24'h000000, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data = {16'h0000, ld_half};
            default: load_data = rdata_word;
        endcase
    end

endmodule

// File: rtl/lsu_bus.sv
// lsu_bus: bridges core load/store requests onto a simple valid/ready bus.
//   clk, reset (async, active-low)
//   Core side : MemRead, MemWrite, Funct3, ALUResult, WriteData in;
//               ReadData, Stall, AccessErr out
//   Bus side  : BusValid, BusWe, BusAddr, BusWData, BusWStrb out;
//               BusReady, BusRData in
// An access runs IDLE -> REQ (until ready or timeout) -> DONE -> IDLE.
// Illegal accesses are rejected in IDLE with a single-cycle AccessErr.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        BusValid,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusWStrb,
    input  logic        BusReady,
    input  logic [31:0] BusRData
);

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
    // Last REQ cycle index that may still wait; TIMEOUT_CYCLES must be >= 1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_reg;
    logic             bus_valid_reg;
    logic             bus_we_reg;
    logic [3:0]       bus_wstrb_reg;
    logic [31:0]      bus_addr_reg;
    logic [31:0]      bus_wdata_reg;
    logic [31:0]      rdata_reg;
    logic [2:0]       funct3_reg;
    logic [1:0]       addr_lo_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic        req_any;
    logic        legal;
    logic        start;
    logic        reject;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_wstrb;
    logic [31:0] load_data;

    // MemWrite wins when both are high: the access is formatted as a store.
    assign req_any = MemRead | MemWrite;

    lsu_format u_format (
        .is_store    (MemWrite),
        .req_funct3  (Funct3),
        .req_addr_lo (ALUResult[1:0]),
        .store_data  (WriteData),
        .legal       (legal),
        .bus_wdata   (fmt_wdata),
        .bus_wstrb   (fmt_wstrb),
        .ld_funct3   (funct3_reg),
        .ld_addr_lo  (addr_lo_reg),
        .rdata_word  (rdata_reg),
        .load_data   (load_data)
    );

    assign start  = (state_reg == IDLE) & req_any & legal;
    assign reject = (state_reg == IDLE) & req_any & ~legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            bus_valid_reg <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_wstrb_reg <= 4'b0000;
            bus_addr_reg  <= 32'h0;
            bus_wdata_reg <= 32'h0;
            rdata_reg     <= 32'h0;
            funct3_reg    <= 3'b000;
            addr_lo_reg   <= 2'b00;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bus_addr_reg  <= {ALUResult[31:2], 2'b00};
                        bus_we_reg    <= MemWrite;
                        bus_wstrb_reg <= MemWrite ? fmt_wstrb : 4'b0000;
                        bus_wdata_reg <= MemWrite ? fmt_wdata : 32'h0;
                        funct3_reg    <= Funct3;
                        addr_lo_reg   <= ALUResult[1:0];
                        cnt_reg       <= '0;
                        err_reg       <= 1'b0;
                        bus_valid_reg <= 1'b1;
                        state_reg     <= REQ;
                    end
                end
                REQ: begin
                    // Ready on the final permitted cycle still completes normally.
                    if (BusReady) begin
                        rdata_reg     <= BusRData;
                        bus_valid_reg <= 1'b0;
                        bus_we_reg    <= 1'b0;
                        bus_wstrb_reg <= 4'b0000;
                        state_reg     <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        rdata_reg     <= 32'h0;
                        err_reg       <= 1'b1;
                        bus_valid_reg <= 1'b0;
                        bus_we_reg    <= 1'b0;
                        bus_wstrb_reg <= 4'b0000;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Core inputs are ignored here so the finishing instruction
                    // cannot start a second access.
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Stall and AccessErr depend on live inputs in IDLE, so reset gates them
    // directly rather than relying on the state register alone.
    assign Stall     = reset & (start | (state_reg == REQ));
    assign AccessErr = reset & (reject | ((state_reg == DONE) & err_reg));
    assign ReadData  = (state_reg == DONE) ? load_data : 32'h0;

    assign BusValid = bus_valid_reg;
    assign BusWe    = bus_we_reg;
    assign BusAddr  = bus_addr_reg;
    assign BusWData = bus_wdata_reg;
    assign BusWStrb = bus_wstrb_reg;

endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: scoreboard-based bench for lsu_bus. Expected bus requests and
// completion results are queued when a core access is driven and compared
// when the access reaches its DONE cycle.
module tb_lsu_bus;

    localparam int TB_TMO = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, AccessErr;
    logic        BusValid, BusWe;
    logic [31:0] BusAddr, BusWData;
    logic [3:0]  BusWStrb;
    logic        BusReady;
    logic [31:0] BusRData;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_bus #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .AccessErr (AccessErr),
        .BusValid  (BusValid),
        .BusWe     (BusWe),
        .BusAddr   (BusAddr),
        .BusWData  (BusWData),
        .BusWStrb  (BusWStrb),
        .BusReady  (BusReady),
        .BusRData  (BusRData)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          reqc;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err, input int reqc);
        exp_t e;
        e.addr = addr; e.we = we; e.strb = strb; e.wdata = wdata;
        e.rdata = rdata; e.err = err; e.reqc = reqc;
        return e;
    endfunction

    task automatic idle_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'h0; WriteData = 32'h0;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rword,
                              input int wt, input bit never, input exp_t e);
        exp_t got_e;
        int   n;
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
        BusReady = 1'b0; BusRData = 32'hFFFF_FFFF;
        sb_q.push_back(e);
        #1;
        chk({name, ":idle_stall"}, 32'(Stall), 32'h1);
        chk({name, ":idle_err"},   32'(AccessErr), 32'h0);
        chk({name, ":idle_valid"}, 32'(BusValid), 32'h0);
        n = 0;
        @(negedge clk);
        while (BusValid === 1'b1 && n < 64) begin
            chk({name, ":addr"},  BusAddr, e.addr);
            chk({name, ":we"},    32'(BusWe), 32'(e.we));
            chk({name, ":strb"},  32'(BusWStrb), 32'(e.strb));
            if (e.we) chk({name, ":wdata"}, BusWData, e.wdata);
            chk({name, ":req_stall"}, 32'(Stall), 32'h1);
            chk({name, ":req_rdata0"}, ReadData, 32'h0);
            BusReady = !never && (n == wt);
            BusRData = BusReady ? rword : 32'hFFFF_FFFF;
            n++;
            @(negedge clk);
        end
        BusReady = 1'b0;
        got_e = sb_q.pop_front();
        chk({name, ":req_cycles"}, 32'(n), 32'(got_e.reqc));
        chk({name, ":done_rdata"}, ReadData, got_e.rdata);
        chk({name, ":done_err"},   32'(AccessErr), 32'(got_e.err));
        chk({name, ":done_stall"}, 32'(Stall), 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({name, ":post_valid"}, 32'(BusValid), 32'h0);
        chk({name, ":post_err"},   32'(AccessErr), 32'h0);
        chk({name, ":post_rdata"}, ReadData, 32'h0);
    endtask

    // Called at a negedge in IDLE; illegal request must be rejected on the spot.
    task automatic run_illegal(input string name, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = 32'h5A5A_5A5A;
        #1;
        chk({name, ":err"},   32'(AccessErr), 32'h1);
        chk({name, ":stall"}, 32'(Stall), 32'h0);
        chk({name, ":valid"}, 32'(BusValid), 32'h0);
        chk({name, ":rdata"}, ReadData, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({name, ":valid_next"}, 32'(BusValid), 32'h0);
        chk({name, ":err_next"},   32'(AccessErr), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        BusReady = 1'b0; BusRData = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst:valid", 32'(BusValid), 32'h0);
        chk("rst:stall", 32'(Stall), 32'h0);
        chk("rst:err",   32'(AccessErr), 32'h0);
        chk("rst:strb",  32'(BusWStrb), 32'h0);
        chk("rst:addr",  BusAddr, 32'h0);
        chk("rst:rdata", ReadData, 32'h0);

        // Release reset and present a request in the same cycle.
        reset = 1'b1;
        run_access("sw", 1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 1'b0,
                   mk(32'h0000_1000, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1));
        run_access("lb", 1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 4, 1'b0,
                   mk(32'h0000_2000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 5));
        run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 4, 1'b0,
                   mk(32'h0000_2000, 1'b0, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 5));
        run_access("sh", 1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h0, 1, 1'b0,
                   mk(32'h0000_3000, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 2));
        run_access("sb", 1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h1234_5678, 32'h0, 0, 1'b0,
                   mk(32'h0000_3000, 1'b1, 4'b0010, 32'h7878_7878, 32'h0, 1'b0, 1));
        run_access("lh", 1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 0, 1'b0,
                   mk(32'h0000_5000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 1));
        run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 2, 1'b0,
                   mk(32'h0000_5000, 1'b0, 4'b0000, 32'h0, 32'h0000_8001, 1'b0, 3));
        run_access("lh_lo", 1'b1, 1'b0, 3'b001, 32'h0000_5000, 32'h0, 32'h8001_7FFF, 0, 1'b0,
                   mk(32'h0000_5000, 1'b0, 4'b0000, 32'h0, 32'h0000_7FFF, 1'b0, 1));
        run_access("lw", 1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 2, 1'b0,
                   mk(32'h0000_6004, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, 3));
        run_access("rw_prio", 1'b1, 1'b1, 3'b010, 32'h0000_7000, 32'h0BAD_C0DE, 32'h1111_2222, 0, 1'b0,
                   mk(32'h0000_7000, 1'b1, 4'b1111, 32'h0BAD_C0DE, 32'h1111_2222, 1'b0, 1));
        run_access("tmo", 1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 0, 1'b1,
                   mk(32'h0000_8000, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, TB_TMO));

        run_illegal("lw_mis",   1'b1, 1'b0, 3'b010, 32'h0000_4002);
        run_illegal("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_4000);
        run_illegal("sh_mis",   1'b0, 1'b1, 3'b001, 32'h0000_3001);
        run_illegal("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_3000);
        run_illegal("rw_f3_100", 1'b1, 1'b1, 3'b100, 32'h0000_3000);

        // Reset pulsed mid-REQ: BusValid must fall without a clock edge.
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_9000;
        @(negedge clk);
        chk("mid:valid_before", 32'(BusValid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid:valid_async", 32'(BusValid), 32'h0);
        chk("mid:stall_async", 32'(Stall), 32'h0);
        chk("mid:addr_async",  BusAddr, 32'h0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("mid:valid_after", 32'(BusValid), 32'h0);
        chk("mid:stall_after", 32'(Stall), 32'h0);
        @(negedge clk);
        run_access("recover", 1'b1, 1'b0, 3'b010, 32'h0000_A000, 32'h0, 32'h1357_9BDF, 1, 1'b0,
                   mk(32'h0000_A000, 1'b0, 4'b0000, 32'h0, 32'h1357_9BDF, 1'b0, 2));

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, bus cycles in REQ before the access is aborted.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- MemRead  in  1  core load request
- MemWrite  in  1  core store request
- Funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ALUResult  in  32  byte address
- WriteData  in  32  store data, rs2
- ReadData  out  32  formatted load result
- Stall  out  1  core holds PC and suppresses RegWrite
- AccessErr  out  1  one-cycle error pulse
- BusValid  out  1  request valid
- BusWe  out  1  1 = write
- BusAddr  out  32  word-aligned address, bits [1:0] = 00
- BusWData  out  32  lane-aligned store data
- BusWStrb  out  4  byte enables
- BusReady  in  1  slave accepts/completes
- BusRData  in  32  read word, valid when BusValid & BusReady

Function
REQ-003 SHALL implement states IDLE, REQ, DONE.
REQ-004 IDLE, (MemRead|MemWrite), legal access: Stall=1 combinationally in the same cycle; register address, data, strobe and BusWe; next state REQ.
REQ-005 MemWrite SHALL take priority when MemRead and MemWrite are both high.
REQ-006 Legal access: Funct3 in {000,001,010,100,101} with alignment.
- Halfword: addr[0]=0.
- Word: addr[1:0]=00.
- Stores: only 000/001/010.
REQ-007 Illegal access in IDLE:
- No bus transaction and no write.
- Stall=0; AccessErr=1 for that cycle; ReadData=0.
- State stays IDLE.
REQ-008 REQ: BusValid=1 and Stall=1; bus outputs stable until BusValid & BusReady.
REQ-009 On BusValid & BusReady: capture BusRData; next state DONE.
REQ-010 Timeout: when the REQ cycle counter reaches TIMEOUT_CYCLES without BusReady, drop BusValid and go to DONE with captured data = 0 and AccessErr=1 in DONE.
REQ-011 DONE: Stall=0; ReadData = formatted captured data; MemRead/MemWrite ignored; next state IDLE.
- Prevents the completing instruction from re-triggering.
REQ-012 Minimum latency is 3 cycles (IDLE, REQ with immediate ready, DONE); each extra wait cycle adds 1.
REQ-013 Load format, with byte lane taken by addr[1:0] and halfword by addr[1]:
- lb/lh: sign-extended.
- lbu/lhu: zero-extended.
- lw: unchanged.
REQ-014 Store strobes and data:
- sb: strobe 0001<<addr[1:0], byte replicated on all lanes.
- sh: strobe 0011<<(2*addr[1]), halfword replicated.
- sw: strobe 1111.
REQ-015 BusWStrb SHALL be 0000 for reads.
REQ-016 ReadData SHALL be 0 in every state other than DONE.
REQ-017 The timeout counter is 8+ bits wide, sized from TIMEOUT_CYCLES; it clears on entry to REQ and never wraps.

Reset
REQ-018 reset=0 SHALL asynchronously force:
- State IDLE.
- BusValid, BusWe, BusWStrb, AccessErr, Stall = 0.
- BusAddr, BusWData, ReadData, captured data, counter = 0.
REQ-019 Reset asserted during REQ SHALL drop BusValid immediately, without waiting for a clock edge; the transaction is abandoned.
REQ-020 After reset deasserts, the first request SHALL be accepted on the first rising edge.

Structure
REQ-021 Package lsu_pkg SHALL hold:
- State enum.
- Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Default TIMEOUT_CYCLES.
REQ-022 Sub-module lsu_format SHALL be purely combinational and hold the load extract/extend and store align/strobe logic; it is instantiated once.

Verification
REQ-023 sw 0x1000, WriteData 0xDEADBEEF, BusReady high in first REQ cycle -> BusWStrb 1111, BusAddr 0x1000, Stall high 2 cycles, DONE on cycle 3.
REQ-024 lb addr 0x2003, BusRData 0x80FF_FF7F, ready after 4 wait cycles -> ReadData 0xFFFFFF80 in DONE; lbu same -> 0x00000080.
REQ-025 sh addr 0x3002, WriteData 0x0000ABCD -> BusWStrb 1100, BusWData 0xABCDABCD.
REQ-026 lw addr 0x4002 -> no BusValid, AccessErr pulse 1 cycle, Stall 0; Funct3 011 load -> same response.
REQ-027 Two cases:
- lw with BusReady held low, TIMEOUT_CYCLES=4 -> BusValid drops after 4 REQ cycles, AccessErr in DONE, ReadData 0.
- reset pulsed mid-REQ -> BusValid 0 asynchronously, state IDLE.
